fp_f2i: RTL and testbench

FP_F2I -- requirements
Module: fp_f2i

---
 rtl/fp_f2i.sv | 237 +++++++++++++++++++++++
 tb/tb_fp_f2i.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_f2i.sv
// ---------------------------------------------------------------------------
// fp_f2i -- multi-cycle IEEE-754 binary32 to signed 32-bit integer converter.
//
// Ports
//   clk      : clock, all state updates on the rising edge
//   rst      : asynchronous active-high reset
//   start    : one-cycle request, sampled together with in1/round_m when
//              the unit is idle
//   in1      : binary32 operand
//   round_m  : rounding mode (000 RNe, 001 RZ, 010 RD, 011 RU, 100 RNa,
//              anything else behaves as RNe)
//   out      : two's-complement integer result
//   busy     : high from the cycle after an accepted start through the
//              done cycle
//   done     : one-cycle pulse; out/inv/inexact are valid from this cycle
//              until they are overwritten by the next conversion
//   inv      : invalid (NaN, infinity or out-of-range result)
//   inexact  : result differs from the operand value (never set with inv)
//
// Handshake: a request is accepted on a rising edge where start=1 and the
// unit is idle with busy=0. Any start seen while busy=1, including during
// the done cycle, is dropped. Exactly one done pulse follows each accepted
// request unless rst intervenes, in which case no done pulse is produced.
//
// Optional build macro FP_F2I_FASTSHIFT_EN: the alignment shifter moves four
// bit positions per cycle while at least four remain. Results are identical
// with and without it; only the latency changes.
//
// Datapath layout (35 bits): [34:3] integer magnitude, [2] guard,
// [1] round, [0] sticky.
// ---------------------------------------------------------------------------
module fp_f2i (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [31:0] in1,
   input  logic [2:0]  round_m,
   output logic [31:0] out,
   output logic        busy,
   output logic        done,
   output logic        inv,
   output logic        inexact
);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      UNPACK = 3'd1,
      SHIFT  = 3'd2,
      ROUND  = 3'd3,
      DONE   = 3'd4
   } state_t;

   state_t      state;
   logic [31:0] op_q;       // latched operand
   logic [2:0]  rm_q;       // latched rounding mode
   logic [34:0] dp;         // alignment datapath
   logic [4:0]  cnt;        // remaining shift steps (bit positions)
   logic        dir_left;   // 1: shift left, 0: shift right
   logic        bad_q;      // operand classified invalid during UNPACK
   logic        sat_neg_q;  // saturate towards 0x80000000 when invalid

   // ---------------- operand classification ----------------
   logic [7:0]  exp_w;
   logic        is_special;
   logic        is_nan;
   logic        is_big;
   logic        is_small;
   logic        op_nonzero;

   always_comb begin
      exp_w      = op_q[30:23];
      is_special = (exp_w == 8'd255);
      is_nan     = is_special && (op_q[22:0] != 23'd0);
      // |x| >= 2^31 is out of range, except exactly -2^31.
      is_big     = (exp_w >= 8'd158) && (op_q != 32'hCF00_0000);
      // |x| < 0.5 (includes zeros and subnormals).
      is_small   = (exp_w < 8'd126);
      op_nonzero = (op_q[30:0] != 31'd0);
   end

   // Shift distance from the biased exponent. Normal-path exponents lie in
   // 126..158, so 150-E and E-150 both fit in five bits and can be computed
   // modulo 32 from the low exponent bits (150 mod 32 = 22).
   logic [4:0] rshift_n;
   logic [4:0] lshift_n;
   assign rshift_n = 5'd22 - exp_w[4:0];
   assign lshift_n = exp_w[4:0] - 5'd22;

   // ---------------- alignment shifter ----------------
   logic        step4;
   logic [34:0] dp_shift;
   logic [4:0]  cnt_nxt;

`ifdef FP_F2I_FASTSHIFT_EN
   assign step4 = (cnt >= 5'd4);
`else
   assign step4 = 1'b0;
`endif

   always_comb begin
      dp_shift = dp;
      if (dir_left) begin
         dp_shift = step4 ? (dp << 4) : (dp << 1);
      end else if (step4) begin
         // Everything leaving the guard/round/sticky window folds into sticky.
         dp_shift = {4'b0000, dp[34:5], |dp[4:0]};
      end else begin
         dp_shift = {1'b0, dp[34:2], dp[1] | dp[0]};
      end
      cnt_nxt = step4 ? (cnt - 5'd4) : (cnt - 5'd1);
   end

   // ---------------- rounding ----------------
   logic [31:0] mag;
   logic        g_bit;
   logic        s_bit;
   logic        lsb_bit;
   logic        sign_w;
   logic        inc;
   logic [32:0] rmag;
   logic        ovf;
   logic [31:0] res;

   always_comb begin
      mag     = dp[34:3];
      g_bit   = dp[2];
      s_bit   = dp[1] | dp[0];
      lsb_bit = dp[3];
      sign_w  = op_q[31];
      case (rm_q)
         3'b001:  inc = 1'b0;                        // RZ
         3'b010:  inc = sign_w & (g_bit | s_bit);    // RD
         3'b011:  inc = ~sign_w & (g_bit | s_bit);   // RU
         3'b100:  inc = g_bit;                       // RNa
         default: inc = g_bit & (s_bit | lsb_bit);   // RNe
      endcase
      rmag = {1'b0, mag} + {32'd0, inc};
      // Negative side may reach 2^31 exactly (-2^31 is representable).
      ovf  = sign_w ? (rmag > 33'h0_8000_0000) : (rmag > 33'h0_7FFF_FFFF);
      res  = sign_w ? (~rmag[31:0] + 32'd1) : rmag[31:0];
   end

   // ---------------- control FSM ----------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         op_q      <= 32'd0;
         rm_q      <= 3'd0;
         dp        <= 35'd0;
         cnt       <= 5'd0;
         dir_left  <= 1'b0;
         bad_q     <= 1'b0;
         sat_neg_q <= 1'b0;
         out       <= 32'd0;
         busy      <= 1'b0;
         done      <= 1'b0;
         inv       <= 1'b0;
         inexact   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (start && !busy) begin
                  op_q  <= in1;
                  rm_q  <= round_m;
                  busy  <= 1'b1;
                  state <= UNPACK;
               end
            end

            UNPACK: begin
               sat_neg_q <= op_q[31] & ~is_nan;
               dir_left  <= 1'b0;
               if (is_special || is_big) begin
                  bad_q <= 1'b1;
                  dp    <= 35'd0;
                  cnt   <= 5'd0;
                  state <= ROUND;
               end else if (is_small) begin
                  // Guard is 0 because |x| < 0.5; any nonzero operand only
                  // contributes sticky, which lets directed modes round to 1.
                  bad_q <= 1'b0;
                  dp    <= {34'd0, op_nonzero};
                  cnt   <= 5'd0;
                  state <= ROUND;
               end else begin
                  bad_q <= 1'b0;
                  dp    <= {8'd0, 1'b1, op_q[22:0], 3'b000};
                  if (exp_w >= 8'd150) begin
                     dir_left <= 1'b1;
                     cnt      <= lshift_n;
                     state    <= (lshift_n == 5'd0) ? ROUND : SHIFT;
                  end else begin
                     cnt   <= rshift_n;
                     state <= SHIFT;
                  end
               end
            end

            SHIFT: begin
               dp  <= dp_shift;
               cnt <= cnt_nxt;
               if (cnt_nxt == 5'd0) begin
                  state <= ROUND;
               end
            end

            ROUND: begin
               if (bad_q || ovf) begin
                  out     <= sat_neg_q ? 32'h8000_0000 : 32'h7FFF_FFFF;
                  inv     <= 1'b1;
                  inexact <= 1'b0;
               end else begin
                  out     <= res;
                  inv     <= 1'b0;
                  inexact <= g_bit | s_bit;
               end
               done  <= 1'b1;
               state <= DONE;
            end

            DONE: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= IDLE;
            end

            default: begin
               state <= IDLE;
               busy  <= 1'b0;
               done  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fp_f2i.sv
// ---------------------------------------------------------------------------
// tb_fp_f2i -- directed, table-driven bench for fp_f2i.
// Each record carries an operand, a rounding mode and the hand-computed
// integer result and flags. Latency is checked against 3 + S where S is the
// number of shift cycles for the build in use.
// ---------------------------------------------------------------------------
module tb_fp_f2i;

   logic        clk;
   logic        rst;
   logic        start;
   logic [31:0] in1;
   logic [2:0]  round_m;
   logic [31:0] out;
   logic        busy;
   logic        done;
   logic        inv;
   logic        inexact;

   int n_vec = 0;
   int n_bad = 0;

   fp_f2i dut (
      .clk     (clk),
      .rst     (rst),
      .start   (start),
      .in1     (in1),
      .round_m (round_m),
      .out     (out),
      .busy    (busy),
      .done    (done),
      .inv     (inv),
      .inexact (inexact)
   );

   // ---------------- clock ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] in1;
      logic [2:0]  rm;
      logic [31:0] out;
      logic        inv;
      logic        inx;
   } vec_t;

   localparam int NV = 30;
   vec_t vt [0:NV-1];

   // ---------------- checks ----------------
   task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic chk1(input string name, input logic act, input logic exp);
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   // Shift cycles for an operand: zero for the skip classes, otherwise the
   // alignment distance |E-150|, compressed in the fast-shift build.
   function automatic int exp_lat(input logic [31:0] x);
      int e;
      int n;
      e = int'(x[30:23]);
      if (e == 255 || (e >= 158 && x != 32'hCF00_0000) || e < 126) return 3;
      n = (e >= 150) ? (e - 150) : (150 - e);
`ifdef FP_F2I_FASTSHIFT_EN
      return 3 + n / 4 + n % 4;
`else
      return 3 + n;
`endif
   endfunction

   task automatic run_vec(input vec_t v, input string tag);
      int   cnt;
      logic seen;
      @(negedge clk);
      in1     = v.in1;
      round_m = v.rm;
      start   = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      cnt  = 0;
      seen = 1'b0;
      while (!seen && cnt < 200) begin
         @(negedge clk);
         cnt++;
         if (cnt == 1) chk1({tag, " busy_after_start"}, busy, 1'b1);
         if (done) seen = 1'b1;
      end
      n_vec++;
      if (!seen) begin
         n_bad++;
         $display("FAIL %s timeout: no done within %0d cycles", tag, cnt);
      end else begin
         chk32({tag, " out"}, out, v.out);
         chk1({tag, " inv"}, inv, v.inv);
         chk1({tag, " inexact"}, inexact, v.inx);
         chk32({tag, " latency"}, cnt, exp_lat(v.in1));
         @(negedge clk);
         chk1({tag, " done_pulse_len"}, done, 1'b0);
         chk1({tag, " busy_released"}, busy, 1'b0);
      end
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int   cyc;
      logic seen;
      string nm;

      //           in1           rm     out           inv   inx
      vt[0]  = '{32'h3F80_0000, 3'd0, 32'h0000_0001, 1'b0, 1'b0}; // 1.0
      vt[1]  = '{32'h4020_0000, 3'd0, 32'h0000_0002, 1'b0, 1'b1}; // 2.5 RNe
      vt[2]  = '{32'h4020_0000, 3'd4, 32'h0000_0003, 1'b0, 1'b1}; // 2.5 RNa
      vt[3]  = '{32'hC020_0000, 3'd2, 32'hFFFF_FFFD, 1'b0, 1'b1}; // -2.5 RD
      vt[4]  = '{32'hC020_0000, 3'd1, 32'hFFFF_FFFE, 1'b0, 1'b1}; // -2.5 RZ
      vt[5]  = '{32'hCF00_0000, 3'd0, 32'h8000_0000, 1'b0, 1'b0}; // -2^31
      vt[6]  = '{32'h4F00_0000, 3'd0, 32'h7FFF_FFFF, 1'b1, 1'b0}; // 2^31
      vt[7]  = '{32'h7FC0_0000, 3'd0, 32'h7FFF_FFFF, 1'b1, 1'b0}; // NaN
      vt[8]  = '{32'h3E80_0000, 3'd3, 32'h0000_0001, 1'b0, 1'b1}; // 0.25 RU
      vt[9]  = '{32'h3E80_0000, 3'd0, 32'h0000_0000, 1'b0, 1'b1}; // 0.25 RNe
      vt[10] = '{32'h8000_0000, 3'd2, 32'h0000_0000, 1'b0, 1'b0}; // -0 RD
      vt[11] = '{32'h8000_0000, 3'd3, 32'h0000_0000, 1'b0, 1'b0}; // -0 RU
      vt[12] = '{32'hFF80_0000, 3'd0, 32'h8000_0000, 1'b1, 1'b0}; // -Inf
      vt[13] = '{32'hBE80_0000, 3'd2, 32'hFFFF_FFFF, 1'b0, 1'b1}; // -0.25 RD
      vt[14] = '{32'h3FC0_0000, 3'd0, 32'h0000_0002, 1'b0, 1'b1}; // 1.5 RNe
      vt[15] = '{32'h3FC0_0000, 3'd1, 32'h0000_0001, 1'b0, 1'b1}; // 1.5 RZ
      vt[16] = '{32'h3FC0_0000, 3'd2, 32'h0000_0001, 1'b0, 1'b1}; // 1.5 RD
      vt[17] = '{32'h3FC0_0000, 3'd3, 32'h0000_0002, 1'b0, 1'b1}; // 1.5 RU
      vt[18] = '{32'h3F00_0000, 3'd0, 32'h0000_0000, 1'b0, 1'b1}; // 0.5 RNe
      vt[19] = '{32'h3F00_0000, 3'd4, 32'h0000_0001, 1'b0, 1'b1}; // 0.5 RNa
      vt[20] = '{32'h4EFF_FFFF, 3'd0, 32'h7FFF_FF80, 1'b0, 1'b0}; // max < 2^31
      vt[21] = '{32'h4060_0000, 3'd0, 32'h0000_0004, 1'b0, 1'b1}; // 3.5 RNe
      vt[22] = '{32'h4B00_0001, 3'd0, 32'h0080_0001, 1'b0, 1'b0}; // e=23
      vt[23] = '{32'hCF00_0001, 3'd0, 32'h8000_0000, 1'b1, 1'b0}; // < -2^31
      vt[24] = '{32'h4020_0000, 3'd7, 32'h0000_0002, 1'b0, 1'b1}; // bad mode
      vt[25] = '{32'h0000_0001, 3'd3, 32'h0000_0001, 1'b0, 1'b1}; // subnorm RU
      vt[26] = '{32'hFFC0_0000, 3'd2, 32'h7FFF_FFFF, 1'b1, 1'b0}; // -NaN
      vt[27] = '{32'h7F80_0000, 3'd1, 32'h7FFF_FFFF, 1'b1, 1'b0}; // +Inf
      vt[28] = '{32'h3F7F_FFFF, 3'd1, 32'h0000_0000, 1'b0, 1'b1}; // ~1 RZ
      vt[29] = '{32'hC060_0000, 3'd4, 32'hFFFF_FFFC, 1'b0, 1'b1}; // -3.5 RNa

      // ---- reset state ----
      rst     = 1'b1;
      start   = 1'b0;
      in1     = 32'd0;
      round_m = 3'd0;
      #1;
      chk32("reset out", out, 32'd0);
      chk1("reset busy", busy, 1'b0);
      chk1("reset done", done, 1'b0);
      chk1("reset inv", inv, 1'b0);
      chk1("reset inexact", inexact, 1'b0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;

      // ---- table ----
      for (int i = 0; i < NV; i++) begin
         nm = $sformatf("vec%0d", i);
         run_vec(vt[i], nm);
      end

      // ---- start during the done cycle is dropped ----
      @(negedge clk);
      in1 = 32'h4020_0000; round_m = 3'd0; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      cyc = 0; seen = 1'b0;
      while (!seen && cyc < 200) begin
         @(negedge clk);
         cyc++;
         if (done) seen = 1'b1;
      end
      n_vec++;
      chk1("done_cycle_start first done", seen, 1'b1);
      in1 = 32'h3F80_0000; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      seen = 1'b0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (k == 0) chk1("done_cycle_start busy", busy, 1'b0);
         if (done) seen = 1'b1;
      end
      chk1("done_cycle_start no second done", seen, 1'b0);
      chk32("done_cycle_start out held", out, 32'h0000_0002);

      // ---- abort by reset; second start while busy is ignored ----
      @(negedge clk);
      in1 = 32'h3F80_0000; round_m = 3'd0; start = 1'b1;
      @(posedge clk);                 // cycle 0
      #1 start = 1'b0;
      repeat (4) @(posedge clk);
      @(negedge clk);
      in1 = 32'h4020_0000; start = 1'b1;
      @(posedge clk);                 // cycle 5
      #1 start = 1'b0;
      chk1("abort busy before rst", busy, 1'b1);
      repeat (5) @(posedge clk);      // cycle 10
      #2 rst = 1'b1;
      #1;
      n_vec++;
      chk32("abort out", out, 32'd0);
      chk1("abort busy", busy, 1'b0);
      chk1("abort done", done, 1'b0);
      chk1("abort inv", inv, 1'b0);
      chk1("abort inexact", inexact, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      seen = 1'b0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (done || busy) seen = 1'b1;
      end
      chk1("abort no activity after rst", seen, 1'b0);

      // ---- fresh request after the abort ----
      run_vec(vt[0], "post_abort");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

   // Global guard so the run always ends.
   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

endmodule
